// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer: load/start/stop/auto_reload in, count/tc/busy out.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_val, start, stop, auto_reload,
    input  count, tc, busy
  );

  modport slave (
    input  load, load_val, start, stop, auto_reload,
    output count, tc, busy
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable start/stop down counter with one-cycle terminal-count pulse and optional auto-reload.
// Optional tick prescaler enabled by defining DCT_PRESCALE_EN (divide ratio PRESCALE, 2..256).
module down_counter_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  down_counter_timer_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count_q, count_next;
  logic [WIDTH-1:0] reload_q, reload_next;
  logic             tc_q, tc_next;
  logic             tick;

`ifdef DCT_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_next;

  // Prescale phase only advances while genuinely running; load/stop or leaving RUN park it at zero.
  always_comb begin
    pre_next = '0;
    tick     = 1'b0;
    if (state == RUN && !bus.load && !bus.stop) begin
      if (pre_q == PW'(PRESCALE - 1)) begin
        tick = 1'b1;
      end else begin
        pre_next = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_next;
    end
  end
`else
  assign tick = (state == RUN);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state    <= state_next;
      count_q  <= count_next;
      reload_q <= reload_next;
      tc_q     <= tc_next;
    end
  end

  // Priority chain: load, then stop, then start, then the running tick.
  always_comb begin
    state_next  = state;
    count_next  = count_q;
    reload_next = reload_q;
    tc_next     = 1'b0;
    if (bus.load) begin
      count_next  = bus.load_val;
      reload_next = bus.load_val;
      state_next  = IDLE;
    end else if (bus.stop) begin
      state_next = IDLE;
    end else if (bus.start && state == IDLE) begin
      if (count_q != '0) begin
        state_next = RUN;
      end
    end else if (state == RUN && tick) begin
      if (count_q > WIDTH'(1)) begin
        count_next = count_q - WIDTH'(1);
      end else if (bus.auto_reload && reload_q != '0) begin
        count_next = reload_q;
        tc_next    = 1'b1;
      end else begin
        // Terminal tick in one-shot mode; never go below zero.
        count_next = '0;
        tc_next    = 1'b1;
        state_next = IDLE;
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: stimulus pushes model predictions, a monitor pops and compares.
module tb_down_counter_timer;

  localparam int W = 4;
  localparam int P = 4;
`ifdef DCT_PRESCALE_EN
  localparam int TICKDIV = P;
`else
  localparam int TICKDIV = 1;
`endif

  typedef struct {
    int countVal;
    bit tcVal;
    bit busyVal;
  } expect_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  expect_t expQ[$];

  // Reference model: a countdown expressed as remaining value, running flag and cycles into the current tick.
  int mCount;
  int mReload;
  bit mRunning;
  int mPhase;
  bit mTc;

  down_counter_timer_if #(.WIDTH(W)) bus ();

  down_counter_timer #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic modelReset();
    mCount   = 0;
    mReload  = 0;
    mRunning = 1'b0;
    mPhase   = 0;
    mTc      = 1'b0;
  endtask

  task automatic modelStep(input bit ld, input int v, input bit st, input bit sp, input bit ar);
    mTc = 1'b0;
    if (ld) begin
      mCount   = v;
      mReload  = v;
      mRunning = 1'b0;
      mPhase   = 0;
    end else if (sp) begin
      mRunning = 1'b0;
      mPhase   = 0;
    end else if (st && !mRunning) begin
      if (mCount != 0) begin
        mRunning = 1'b1;
        mPhase   = 0;
      end
    end else if (mRunning) begin
      mPhase++;
      if (mPhase == TICKDIV) begin
        mPhase = 0;
        if (mCount > 1) begin
          mCount--;
        end else begin
          mTc = 1'b1;
          if (ar && mReload != 0) begin
            mCount = mReload;
          end else begin
            mCount   = 0;
            mRunning = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit ld, input int v, input bit st, input bit sp, input bit ar);
    expect_t e;
    @(negedge clk);
    bus.load        = ld;
    bus.load_val    = W'(v);
    bus.start       = st;
    bus.stop        = sp;
    bus.auto_reload = ar;
    modelStep(ld, v, st, sp, ar);
    e.countVal = mCount;
    e.tcVal    = mTc;
    e.busyVal  = mRunning;
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input int n, input bit ar);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, ar);
  endtask

  // Monitor: outputs are presented every cycle, so each edge consumes one prediction.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("count", int'(bus.count), e.countVal);
        checkOutput("tc", int'(bus.tc), int'(e.tcVal));
        checkOutput("busy", int'(bus.busy), int'(e.busyVal));
      end
    end
  end

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b0;
    bus.load        = 1'b0;
    bus.load_val    = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.auto_reload = 1'b0;
    modelReset();
    #2;
    checkOutput("reset_count", int'(bus.count), 0);
    checkOutput("reset_tc", int'(bus.tc), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;

    // Async reset in the middle of a countdown, asserted between edges.
    applyStimulus(1'b1, 9, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idleCycles(3 * TICKDIV, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_count", int'(bus.count), 0);
    checkOutput("async_rst_busy", int'(bus.busy), 0);
    checkOutput("async_rst_tc", int'(bus.tc), 0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idleCycles(3, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idleCycles(2, 1'b0);

    // One-shot from 5.
    applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idleCycles(5 * TICKDIV + 3, 1'b0);

    // Auto-reload from 3.
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idleCycles(10 * TICKDIV, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);

    // Pause at 4 and resume.
    applyStimulus(1'b1, 9, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idleCycles(5 * TICKDIV, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idleCycles(3, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idleCycles(4 * TICKDIV + 2, 1'b0);

    // Priority corner cases.
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b1, 7, 1'b1, 1'b1, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
    idleCycles(2, 1'b0);

    // Maximum load value, one-shot.
    applyStimulus(1'b1, 15, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idleCycles(15 * TICKDIV + 3, 1'b0);

    // Short load of 2 exposes tick spacing.
    applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idleCycles(2 * TICKDIV + 3, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom % 16) == 0, int'($urandom_range(0, 15)),
                    ($urandom % 4) == 0, ($urandom % 12) == 0, ($urandom % 3) != 0);
    end

    // Drain the scoreboard with a bounded wait.
    begin
      int guard;
      guard = 0;
      while (expQ.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      #3;
      checkOutput("scoreboard_drained", expQ.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, start/stop-controlled down counter with terminal-count pulse and optional auto-reload.
- Complements the team's ripple up-counter: it counts down from a programmed value to zero.
- Used as a countdown or periodic-tick generator alongside the counter blocks in the COUNTERS group.

Parameters:
WIDTH, 4, bit width of count, load_val and internal reload register
PRESCALE, 4, tick divide ratio; used only when DCT_PRESCALE_EN is defined; legal range 2..256

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-low; the block is in reset while rst=0
load  input  1  one-cycle load strobe
load_val  input  WIDTH  value copied into count and the reload register on load
start  input  1  begin or resume counting
stop  input  1  pause counting; count holds
auto_reload  input  1  1 = reload at terminal count and keep running; 0 = one-shot
count  output  WIDTH  current counter value, registered
tc  output  1  terminal-count pulse, registered, one cycle wide
busy  output  1  1 while state=RUN

Behaviour:
- One clock domain (clk); all outputs registered.
- Reset (rst=0, asynchronous, takes effect without a clock edge):
  - count=0, reload_reg=0, tc=0, busy=0, state=IDLE.
  - Prescale counter (if present) cleared.
- States: IDLE and RUN. busy = (state==RUN).
- Per-edge priority: load > stop > start > tick.
- load, any state:
  - count<=load_val, reload_reg<=load_val, state<=IDLE, tc<=0.
  - start and stop in the same cycle are ignored.
- start in IDLE:
  - If count!=0: state<=RUN.
  - If count==0: ignored; block stays IDLE.
  - start in RUN: no effect.
- stop in RUN: state<=IDLE; count holds its value. A later start resumes from the held value.
- stop and start in the same cycle: stop wins.
- Tick:
  - Without the prescaler, tick=1 on every cycle in RUN.
  - The first tick occurs at the edge after the edge that entered RUN.
- On each tick in RUN:
  - count>1: count<=count-1.
  - count==1, auto_reload==0: count<=0, tc<=1, state<=IDLE.
  - count==1, auto_reload==1, reload_reg!=0: count<=reload_reg, tc<=1, state stays RUN.
  - auto_reload is sampled only at the terminal tick.
- tc:
  - High for exactly the one cycle after the terminal edge; 0 otherwise.
  - In one-shot mode, tc and busy=0 appear together.
- Arithmetic rules:
  - count never underflows and never wraps below 0.
  - The only wrap-around is the reload in auto_reload mode.
- Periods:
  - One-shot from load value L: terminal edge is L ticks after entering RUN.
  - Auto-reload: period = reload_reg ticks.
- Reset mid-run: immediate return to reset values; no tc is generated.

Optional Feature:
- Macro: DCT_PRESCALE_EN.
- Defined:
  - An internal prescale counter (width = ceil(log2(PRESCALE))) runs only in RUN.
  - tick=1 once every PRESCALE cycles in RUN.
  - The first tick comes PRESCALE cycles after entering RUN.
  - The prescale counter is cleared on reset, load, stop, and on entering RUN.
  - count, tc and busy otherwise behave as above.
- Not defined: no prescale logic; tick=1 on every RUN cycle; PRESCALE is ignored.

Test Plan:
- Async reset mid-count: load 9, start, after 3 cycles drive rst=0 between clock edges -> count=0, busy=0, tc=0 immediately without a clock edge; after release, block stays IDLE.
- One-shot: load 5, auto_reload=0, start -> count 5,4,3,2,1,0 on successive edges; tc=1 for exactly one cycle with count=0; busy falls in the same cycle; count stays 0.
- Auto-reload: load 3, auto_reload=1, start -> count 3,2,1,3,2,1,3...; tc pulses every 3 cycles; busy stays 1.
- Pause/resume: load 9, start, stop when count=4 -> count holds 4 for 3 idle cycles with busy=0; start -> 3,2,1,0 follow.
- Priority: start with count=0 -> busy stays 0. load 7 with start=1 and stop=1 in the same cycle -> count=7, IDLE. start+stop together in IDLE -> stays IDLE.
- Max value / prescaler: load 15, one-shot -> 15 ticks to tc. With DCT_PRESCALE_EN and PRESCALE=4, load 2 -> count steps every 4 cycles; tc appears 8 cycles after entering RUN.
